// File: rtl/cpu_pkg.sv
// Shared CPU definitions: op-code encoding (common with the ALU) and memory-stage FSM states.
package cpu_pkg;

  localparam logic [5:0] OP_ADD    = 6'b000001;
  localparam logic [5:0] OP_SUB    = 6'b000010;
  localparam logic [5:0] OP_AND    = 6'b000100;
  localparam logic [5:0] OP_OR     = 6'b000101;
  localparam logic [5:0] OP_XOR    = 6'b000110;
  localparam logic [5:0] OP_SLT    = 6'b000111;
  localparam logic [5:0] OP_LDR_DM = 6'b001001;
  localparam logic [5:0] OP_STR_DM = 6'b001010;
  localparam logic [5:0] OP_LDR_IM = 6'b001011;

  typedef enum logic [1:0] {IDLE, DM_WAIT, IM_WAIT} mem_state_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts wait cycles while enabled; expired flags the cycle in which the count would reach TIMEOUT.
module wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results to writeback or runs a data/image memory access with stall and timeout.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned AW      = 16,
  parameter int unsigned IAW     = 18,
  parameter int unsigned RW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [5:0]    ex_op,
  input  logic [N-1:0]  ex_result,
  input  logic [N-1:0]  ex_sdata,
  input  logic [RW-1:0] ex_rd,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [N-1:0]  dm_wdata,
  input  logic [N-1:0]  dm_rdata,
  input  logic          dm_ack,
  output logic          im_req,
  output logic [IAW-1:0] im_addr,
  input  logic [N-1:0]  im_rdata,
  input  logic          im_ack,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [N-1:0]  wb_data,
  output logic          mem_err
);

  mem_state_t r_state;
  logic       r_ld;
  logic       w_accept;
  logic       w_dm_op;
  logic       w_im_op;
  logic       w_dm_oor;
  logic       w_im_oor;
  logic       w_tmr_clear;
  logic       w_tmr_en;
  logic       w_expired;

  assign ex_ready = rst_n && (r_state == IDLE);
  assign w_accept = ex_valid && ex_ready;
  assign w_dm_op  = (ex_op == OP_LDR_DM) || (ex_op == OP_STR_DM);
  assign w_im_op  = (ex_op == OP_LDR_IM);
  assign w_dm_oor = |ex_result[N-1:AW];
  assign w_im_oor = |ex_result[N-1:IAW];

  // The timer only runs while a request is outstanding and no ack has arrived this cycle.
  assign w_tmr_clear = (r_state == IDLE);
  assign w_tmr_en    = ((r_state == DM_WAIT) && !dm_ack) || ((r_state == IM_WAIT) && !im_ack);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_tmr_clear),
    .i_en     (w_tmr_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ld     <= 1'b0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      im_req   <= 1'b0;
      im_addr  <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      mem_err  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            wb_rd <= ex_rd;
            if ((w_dm_op && w_dm_oor) || (w_im_op && w_im_oor)) begin
              mem_err  <= 1'b1;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_data  <= '0;
            end else if (w_dm_op) begin
              r_state  <= DM_WAIT;
              r_ld     <= (ex_op == OP_LDR_DM);
              dm_req   <= 1'b1;
              dm_we    <= (ex_op == OP_STR_DM);
              dm_addr  <= ex_result[AW-1:0];
              dm_wdata <= ex_sdata;
            end else if (w_im_op) begin
              r_state <= IM_WAIT;
              im_req  <= 1'b1;
              im_addr <= ex_result[IAW-1:0];
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= is_alu_op(ex_op);
              wb_data  <= ex_result;
            end
          end
        end
        DM_WAIT: begin
          // An ack arriving in the expiry cycle still completes normally.
          if (dm_ack) begin
            r_state  <= IDLE;
            dm_req   <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= r_ld;
            wb_data  <= r_ld ? dm_rdata : '0;
          end else if (w_expired) begin
            r_state  <= IDLE;
            dm_req   <= 1'b0;
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_data  <= '0;
          end
        end
        IM_WAIT: begin
          if (im_ack) begin
            r_state  <= IDLE;
            im_req   <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= 1'b1;
            wb_data  <= im_rdata;
          end else if (w_expired) begin
            r_state  <= IDLE;
            im_req   <= 1'b0;
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_data  <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level outcome model.
module tb_mem_stage;

  localparam int N = 32, AW = 16, IAW = 18, RW = 4, TO = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ex_valid = 1'b0;
  logic           ex_ready;
  logic [5:0]     ex_op = '0;
  logic [N-1:0]   ex_result = '0;
  logic [N-1:0]   ex_sdata = '0;
  logic [RW-1:0]  ex_rd = '0;
  logic           dm_req, dm_we;
  logic [AW-1:0]  dm_addr;
  logic [N-1:0]   dm_wdata;
  logic [N-1:0]   dm_rdata = '0;
  logic           dm_ack = 1'b0;
  logic           im_req;
  logic [IAW-1:0] im_addr;
  logic [N-1:0]   im_rdata = '0;
  logic           im_ack = 1'b0;
  logic           wb_valid, wb_we;
  logic [RW-1:0]  wb_rd;
  logic [N-1:0]   wb_data;
  logic           mem_err;

  int n_chk = 0;
  int n_err = 0;
  bit err_model = 1'b0;

  mem_stage #(.N(N), .AW(AW), .IAW(IAW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_result(ex_result),
    .ex_sdata(ex_sdata), .ex_rd(ex_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0 = NOP, 1 = ALU, 2 = LDR_DM, 3 = STR_DM, 4 = LDR_IM
  function automatic int op_class(input logic [5:0] op);
    if (op inside {6'b000001, 6'b000010, 6'b000100, 6'b000101, 6'b000110, 6'b000111}) return 1;
    if (op == 6'b001001) return 2;
    if (op == 6'b001010) return 3;
    if (op == 6'b001011) return 4;
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {dm_req, dm_we, im_req, wb_valid, wb_we, mem_err, ex_ready}, 64'd0);
    chk({tag, "_addr"}, {dm_addr, im_addr, wb_rd}, 64'd0);
    chk({tag, "_data"}, {dm_wdata, wb_data}, 64'd0);
  endtask

  // d = number of request cycles that pass before the ack cycle (ack lands in request cycle d+1).
  task automatic do_op(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sdata,
                       input logic [3:0] rd, input int d, input logic [31:0] rdv);
    int cls, mem, exp_req, req_cnt, lat;
    bit oor, bad, got;
    logic exp_we;
    logic [31:0] exp_data;
    cls = op_class(op);
    mem = (cls == 2 || cls == 3) ? 1 : (cls == 4) ? 2 : 0;
    oor = (mem == 1) ? (res[31:16] != 0) : (mem == 2) ? (res[31:18] != 0) : 1'b0;
    exp_req = (mem != 0 && !oor) ? ((d < TO) ? d + 1 : TO) : 0;
    bad = oor || (mem != 0 && d >= TO);
    exp_we = bad ? 1'b0 : (cls == 1 || cls == 2 || cls == 4);
    exp_data = (mem == 0) ? res : (cls == 3) ? 32'd0 : rdv;
    req_cnt = 0; lat = 0; got = 1'b0;

    @(negedge clk);
    chk("wb_pulse_end", wb_valid, 1'b0);
    chk("ready_idle", ex_ready, 1'b1);
    ex_valid = 1'b1; ex_op = op; ex_result = res; ex_sdata = sdata; ex_rd = rd;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_op = 6'($urandom); ex_result = $urandom; ex_sdata = $urandom; ex_rd = 4'($urandom);
    for (int c = 0; c < TO + 8 && !got; c++) begin
      @(negedge clk);
      lat++;
      dm_ack = 1'b0; im_ack = 1'b0; dm_rdata = $urandom; im_rdata = $urandom;
      if (wb_valid) begin
        got = 1'b1;
        chk("wb_rd", wb_rd, rd);
        chk("wb_we", wb_we, exp_we);
        if (!bad) chk("wb_data", wb_data, exp_data);
        chk("latency", lat, exp_req + 1);
        err_model = err_model | bad;
        chk("mem_err", mem_err, err_model);
        chk("req_dropped", {dm_req, im_req}, 2'b00);
      end else begin
        req_cnt++;
        chk("ready_stall", ex_ready, 1'b0);
        if (mem == 1) begin
          chk("dm_req", {dm_req, im_req}, 2'b10);
          chk("dm_addr", dm_addr, res[15:0]);
          chk("dm_we", dm_we, cls == 3);
          chk("dm_wdata", dm_wdata, sdata);
          if (req_cnt == d + 1) begin dm_ack = 1'b1; dm_rdata = rdv; end
          if ($urandom_range(0, 3) == 0) im_ack = 1'b1;
        end else if (mem == 2) begin
          chk("im_req", {dm_req, im_req}, 2'b01);
          chk("im_addr", im_addr, res[17:0]);
          if (req_cnt == d + 1) begin im_ack = 1'b1; im_rdata = rdv; end
          if ($urandom_range(0, 3) == 0) dm_ack = 1'b1;
        end
      end
    end
    dm_ack = 1'b0; im_ack = 1'b0;
    if (!got) chk("wb_seen", 1'b0, 1'b1);
    chk("req_cycles", req_cnt, exp_req);
  endtask

  initial begin
    logic [31:0] rr, res;
    logic [5:0]  op;
    int          d, sel;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", ex_ready, 1'b1);

    // Back-to-back ALU ops retire one per cycle without stalling.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 6'b000001; ex_result = 32'h42; ex_rd = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) ex_valid = 1'b0;
      chk("b2b_valid", {wb_valid, wb_we}, 2'b11);
      chk("b2b_data", wb_data, 32'h42);
      chk("b2b_rd", wb_rd, 4'd3);
      chk("b2b_ready", ex_ready, 1'b1);
    end
    @(negedge clk);
    chk("b2b_end", wb_valid, 1'b0);

    do_op(6'b001001, 32'h0000_0010, 32'h0, 4'd5, 2, 32'hDEAD_BEEF);
    do_op(6'b001010, 32'h0000_0004, 32'h1234, 4'd6, 0, 32'h5555_AAAA);
    do_op(6'b001011, 32'h0000_0200, 32'h0, 4'd7, TO - 1, 32'hCAFE_F00D);
    do_op(6'b001001, 32'h0000_0030, 32'h0, 4'd8, TO - 1, 32'h0BAD_CAFE);
    do_op(6'b001011, 32'h0000_0100, 32'h0, 4'd9, TO + 5, 32'h1111_2222);
    do_op(6'b001001, 32'h0001_0000, 32'h0, 4'd10, 0, 32'h3333_4444);
    do_op(6'b001011, 32'h0004_0000, 32'h0, 4'd11, 0, 32'h3333_4444);
    do_op(6'b111111, 32'h7777_8888, 32'h0, 4'd12, 0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      rr = $urandom;
      case (sel)
        0, 1, 2, 9: op = 6'(rr[2:0] == 3'd3 ? 3'd1 : (rr[2:0] == 3'd0 ? 3'd2 : rr[2:0]));
        3, 4:       op = 6'b001001;
        5:          op = 6'b001010;
        6, 7:       op = 6'b001011;
        default:    op = rr[13:8];
      endcase
      res = $urandom;
      if ($urandom_range(0, 7) != 0) res = (op == 6'b001011) ? (res & 32'h0003_FFFF) : (res & 32'h0000_FFFF);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 3)) : int'($urandom_range(0, 3));
      do_op(op, res, $urandom, 4'($urandom), d, $urandom);
    end

    // Reset in the middle of a data-memory wait, then a stale ack.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 6'b001001; ex_result = 32'h20; ex_rd = 4'd4;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_req1", dm_req, 1'b1);
    @(negedge clk);
    chk("rst_mid_req2", dm_req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst_n = 1'b1; dm_ack = 1'b1; dm_rdata = 32'hFEED_FACE;
    err_model = 1'b0;
    #1;
    chk("rst_mid_ready", ex_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dm_ack = 1'b0;
      chk("late_ack_ignored", {wb_valid, dm_req, mem_err}, 3'b000);
      chk("late_ack_ready", ex_ready, 1'b1);
    end
    do_op(6'b000110, 32'h0BAD_F00D, 32'h0, 4'd1, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
